handshake_array: RTL and testbench
==================================

Name: handshake_array

Overview:
N-channel four-phase request/accept handshake monitor and controller, generalising the single-channel handshake block. Each channel runs an independent protocol FSM that emits a one-cycle E pulse on each accepted transfer. Each channel flags protocol violations and request timeouts in a sticky, individually clearable ERR bit. A shared counter tallies completed handshakes. The block sits between requesters and acceptors, supplying transfer strobes and status to downstream logic.

Parameters:
N, 4, number of independent handshake channels (>=1)
TIMEOUT, 16, max cycles a channel may wait in REQ for A; 0 disables timeout
CW, 8, width of DONE_CNT

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset; highest priority
R  input  N  request per channel
A  input  N  accept/acknowledge per channel
CLR_ERR  input  N  per-channel error clear
E  output  N  one-cycle transfer strobe per channel
BUSY  output  N  channel mid-handshake (state REQ, ACK or REL)
ERR  output  N  channel in ERR state (sticky)
DONE_CNT  output  CW  total completed handshakes, all channels

Behaviour:
- Interface: one clock; reset is synchronous and active-high (CLK, RST). Polarity and synchronicity are fixed.
- Reset: on any edge with RST=1, every channel goes to IDLE and its timer clears. E, BUSY, ERR and DONE_CNT all become 0. This applies mid-handshake with no E pulse and no count.
- Per-channel FSM. Inputs R[i]/A[i] are sampled each edge; notation is (R,A).
- IDLE: (0,0) stay; (1,0) -> REQ, timer=0; A=1 with any R (including simultaneous R&A rise) -> ERR.
- REQ: (1,1) -> ACK; (1,0) handled by timer rule; R=0 with any A (request withdrawn) -> ERR.
- REQ timer rule for (1,0): if TIMEOUT!=0 and timer==TIMEOUT-1 -> ERR, else timer+1. The channel therefore waits at most TIMEOUT cycles in REQ. If A arrives on the timeout edge, ACK wins.
- ACK: (1,1) stay; (0,1) -> REL; (1,0) or (0,0) -> ERR.
- REL: (0,1) stay; (0,0) -> IDLE and the channel counts as completed; R=1 with any A -> ERR.
- ERR: stay until an edge with CLR_ERR[i]=1 and (R,A)=(0,0), then -> IDLE. CLR_ERR is ignored otherwise, and in all non-ERR states.
- E[i]: registered. It is 1 for exactly the first cycle of ACK, i.e. on the REQ->ACK edge only. Outside that cycle it is 0, with no repeat while ACK is held.
- BUSY[i] and ERR[i] are decoded from the registered state, with no combinational path from R/A.
- DONE_CNT: each edge adds the number of channels completing REL->IDLE on that edge (0..N simultaneous). Wraps modulo 2^CW; there is no saturation.
- Timer width is clog2(TIMEOUT+1), minimum 1. Channels are fully independent; one channel's error never affects another.
- Latency: input change to state/output change is 1 edge.

Test Plan:
- Clean handshake, ch0, period 10: R0 rises t=10, A0 t=20, R0 falls t=30, A0 falls t=40. Required: E0=1 for one cycle after the t=20 edge; BUSY0=1 from t=10 to t=40; DONE_CNT=1 after the t=40 edge; ERR0=0 throughout.
- Violation then recovery: A0 rises t=60 with R0=0 -> ERR0=1 at next edge. R0 rises t=70 -> ERR0 stays 1. Drop R0/A0 and pulse CLR_ERR0 -> ERR0=0, IDLE. CLR_ERR0 while R0=1 -> no effect.
- Timeout, TIMEOUT=4: R1 held, A1=0 -> BUSY1 for 4 cycles, then ERR1=1. Same run with A1 rising on the 4th edge -> E1 pulse, no ERR.
- Simultaneous completion, N=4: all channels complete REL->IDLE on the same edge -> DONE_CNT increments by 4 in one cycle. Wrap check with CW=3: count 6 + 4 completions -> 2.
- Reset mid-operation: RST=1 while ch2 is in ACK -> next edge gives BUSY2=0, E=0, ERR=0, DONE_CNT=0. Holding R2=A2=1 after RST falls -> ERR2=1 (IDLE seeing A=1).
- Independence: ch3 forced to ERR while ch0 completes a clean handshake -> ch0 E pulse and count unaffected.

Source files
------------

// File: rtl/handshake_array.sv
// N-channel four-phase request/accept handshake controller: per-channel FSM with
// transfer strobe, sticky clearable error, request timeout and a shared completion count.
module handshake_array #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   R,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   CLR_ERR,
  output logic [N-1:0]   E,
  output logic [N-1:0]   BUSY,
  output logic [N-1:0]   ERR,
  output logic [CW-1:0]  DONE_CNT,
  output logic [3*N-1:0] state_dbg
);

  // Handshake: R rises, A answers, R falls, A falls. A transfer is accepted on the
  // edge that first sees R=1 and A=1 from REQ; any other ordering is a violation.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_REL  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [N-1:0]  done;
  logic [CW-1:0] inc;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          e_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= S_IDLE;
        timer_q <= '0;
        e_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        e_q     <= (state_q == S_REQ) && (state_d == S_ACK);
      end
    end

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
        S_IDLE: begin
          if (A[i]) state_d = S_ERR;
          else if (R[i]) begin
            state_d = S_REQ;
            timer_d = '0;
          end
        end
        S_REQ: begin
          // A arriving on the timeout edge still wins over the timeout.
          if (!R[i]) state_d = S_ERR;
          else if (A[i]) state_d = S_ACK;
          else if ((TIMEOUT != 0) && (timer_q == TW'(TMAX))) state_d = S_ERR;
          else timer_d = timer_q + 1'b1;
        end
        S_ACK: begin
          if (!A[i]) state_d = S_ERR;
          else if (!R[i]) state_d = S_REL;
        end
        S_REL: begin
          if (R[i]) state_d = S_ERR;
          else if (!A[i]) state_d = S_IDLE;
        end
        S_ERR: begin
          if (CLR_ERR[i] && !R[i] && !A[i]) state_d = S_IDLE;
        end
        default: state_d = S_ERR;
      endcase
    end

    assign done[i]             = (state_q == S_REL) && (state_d == S_IDLE);
    assign E[i]                = e_q;
    assign BUSY[i]             = (state_q == S_REQ) || (state_q == S_ACK) || (state_q == S_REL);
    assign ERR[i]              = (state_q == S_ERR);
    assign state_dbg[3*i +: 3] = state_q;
  end

  always_comb begin
    inc = '0;
    for (int k = 0; k < N; k++) inc = inc + CW'(done[k]);
  end

  // Wraps modulo 2^CW by design.
  always_ff @(posedge CLK) begin
    if (RST) DONE_CNT <= '0;
    else     DONE_CNT <= DONE_CNT + inc;
  end

endmodule

// File: tb/tb_handshake_array.sv
// Directed self-checking bench for handshake_array (N=4, TIMEOUT=4, CW=3).
module tb_handshake_array;
  localparam int N  = 4;
  localparam int TO = 4;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   r, a, clr;
  logic [N-1:0]   e, busy, err;
  logic [CW-1:0]  done_cnt;
  logic [3*N-1:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;

  handshake_array #(.N(N), .TIMEOUT(TO), .CW(CW)) dut (
    .CLK(clk), .RST(rst), .R(r), .A(a), .CLR_ERR(clr),
    .E(e), .BUSY(busy), .ERR(err), .DONE_CNT(done_cnt), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks: inputs change 1 time unit after the edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    r = '0; a = '0; clr = '1;
    tick();
    clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r = '0; a = '0; clr = '0;
    tick(); tick();
    checks++; if (e !== 4'h0) begin failures++; $display("FAIL reset_e: got %h want 0", e); end
    checks++; if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL reset_err: got %h want 0", err); end
    checks++; if (done_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", done_cnt); end
    checks++; if (state_dbg !== 12'h000) begin failures++; $display("FAIL reset_state: got %h want 000", state_dbg); end
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_clean();
    r = 4'b0001; tick();
    checks++; if (busy !== 4'b0001 || e !== 4'h0) begin failures++; $display("FAIL clean_req: busy=%h e=%h want busy=1 e=0", busy, e); end
    a = 4'b0001; tick();
    checks++; if (e !== 4'b0001) begin failures++; $display("FAIL clean_e_pulse: got %h want 1", e); end
    tick();
    checks++; if (e !== 4'h0 || busy !== 4'b0001) begin failures++; $display("FAIL clean_e_hold: e=%h busy=%h want e=0 busy=1", e, busy); end
    r = 4'b0000; tick();
    checks++; if (busy !== 4'b0001 || done_cnt !== exp_cnt) begin failures++; $display("FAIL clean_rel: busy=%h cnt=%0d want busy=1 cnt=%0d", busy, done_cnt, exp_cnt); end
    a = 4'b0000; tick();
    exp_cnt = exp_cnt + 3'd1;
    checks++; if (busy !== 4'h0 || done_cnt !== exp_cnt || err !== 4'h0) begin failures++; $display("FAIL clean_done: busy=%h cnt=%0d err=%h want busy=0 cnt=%0d err=0", busy, done_cnt, err, exp_cnt); end
  endtask

  task automatic test_violation();
    a = 4'b0001; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL viol_err: got %h want 1", err); end
    r = 4'b0001; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL viol_sticky: got %h want 1", err); end
    clr = 4'b0001; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL viol_clr_ignored: got %h want 1", err); end
    r = '0; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL viol_clr_a_high: got %h want 1", err); end
    a = '0; tick(); clr = '0;
    checks++; if (err !== 4'h0 || busy !== 4'h0) begin failures++; $display("FAIL viol_cleared: err=%h busy=%h want 0 0", err, busy); end
  endtask

  task automatic test_illegal();
    r = 4'b0001; tick(); r = '0; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL req_withdraw: got %h want 1", err); end
    clear_all();
    r = 4'b0001; tick(); a = 4'b0001; tick(); a = '0; tick();
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL ack_drop_a: got %h want 1", err); end
    clear_all();
    r = 4'b0001; tick(); a = 4'b0001; tick(); r = '0; tick(); r = 4'b0001; tick();
    checks++; if (err !== 4'b0001 || done_cnt !== exp_cnt) begin failures++; $display("FAIL rel_rerequest: err=%h cnt=%0d want 1 %0d", err, done_cnt, exp_cnt); end
    clear_all();
  endtask

  task automatic test_timeout();
    r = 4'b0010;
    for (int k = 0; k < TO; k++) begin
      tick();
      checks++; if (busy !== 4'b0010 || err !== 4'h0) begin failures++; $display("FAIL timeout_wait%0d: busy=%h err=%h want 2 0", k, busy, err); end
    end
    tick();
    checks++; if (err !== 4'b0010 || busy !== 4'h0) begin failures++; $display("FAIL timeout_err: err=%h busy=%h want 2 0", err, busy); end
    clear_all();
    r = 4'b0010;
    for (int k = 0; k < TO; k++) tick();
    a = 4'b0010; tick();
    checks++; if (e !== 4'b0010 || err !== 4'h0) begin failures++; $display("FAIL timeout_ack_wins: e=%h err=%h want 2 0", e, err); end
    r = '0; tick(); a = '0; tick();
    exp_cnt = exp_cnt + 3'd1;
    checks++; if (done_cnt !== exp_cnt) begin failures++; $display("FAIL timeout_cnt: got %0d want %0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_simultaneous();
    for (int pass = 0; pass < 2; pass++) begin
      r = 4'hF; tick(); a = 4'hF; tick();
      checks++; if (e !== 4'hF) begin failures++; $display("FAIL simul_e%0d: got %h want f", pass, e); end
      r = '0; tick(); a = '0; tick();
      exp_cnt = exp_cnt + 3'd4;
      checks++; if (done_cnt !== exp_cnt) begin failures++; $display("FAIL simul_cnt%0d: got %0d want %0d", pass, done_cnt, exp_cnt); end
    end
    checks++; if (done_cnt !== 3'd2) begin failures++; $display("FAIL simul_wrap: got %0d want 2", done_cnt); end
  endtask

  task automatic test_reset_mid();
    r = 4'b0100; tick(); a = 4'b0100; tick();
    rst = 1'b1; tick();
    checks++; if (busy !== 4'h0 || e !== 4'h0 || err !== 4'h0 || done_cnt !== 3'd0) begin failures++; $display("FAIL rstmid: busy=%h e=%h err=%h cnt=%0d want 0 0 0 0", busy, e, err, done_cnt); end
    exp_cnt = '0;
    rst = 1'b0; tick();
    checks++; if (err !== 4'b0100) begin failures++; $display("FAIL rstmid_idle_a: got %h want 4", err); end
    clear_all();
  endtask

  task automatic test_independence();
    a = 4'b1000; tick();
    r = 4'b0001; tick(); a = 4'b1001; tick();
    checks++; if (e !== 4'b0001 || err !== 4'b1000) begin failures++; $display("FAIL indep_e: e=%h err=%h want 1 8", e, err); end
    r = '0; tick(); a = 4'b1000; tick();
    exp_cnt = exp_cnt + 3'd1;
    checks++; if (done_cnt !== exp_cnt || err !== 4'b1000 || busy !== 4'h0) begin failures++; $display("FAIL indep_done: cnt=%0d err=%h busy=%h want %0d 8 0", done_cnt, err, busy, exp_cnt); end
    clear_all();
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL indep_clear: got %h want 0", err); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_violation();
    test_illegal();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
